// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and a
// show-ahead synchronous FIFO presenting received bytes on a valid/ready port.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_serial,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLK_DIV / 2) - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; preset to the idle-high line level.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rxs;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_serial};
        end
    end

    assign rxs = sync_q[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        push_req;
    logic        ferr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // Re-check the start bit half a period in; a high line here is a glitch.
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // Held-low line: wait for idle so a break reports only one error.
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign full    = (count == FULL_CNT);
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push    = push_req && (!full || pop);
    assign drop    = push_req && !push;

    // NOTE: the storage array has no reset; occupancy is tracked by count and
    // m_data is forced to zero while empty, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign m_data     = m_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

    // ------------------------------------------------------------------
    // Status flags; a new drop wins over a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single-frame vectors plus
// hand-written sequences for buffering, overrun, break, glitch and reset.
module tb_uart_rx_fifo;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int HALF       = CLK_DIV / 2;
    localparam int LATENCY    = 2 + HALF + 9 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_serial;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       overrun;
    logic       clr_overrun;
    logic [3:0] fifo_count;

    uart_rx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observer on the falling edge: accepted bytes, error pulses, m_valid timing.
    logic [7:0] rxq[$];
    int         ferr_cnt    = 0;
    int         mv_rise_cyc = -1;
    int         mv_high     = 0;
    logic       mv_prev     = 1'b0;

    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) rxq.push_back(m_data);
        if (frame_err === 1'b1) ferr_cnt++;
        if (m_valid === 1'b1 && mv_prev !== 1'b1 && mv_rise_cyc < 0) mv_rise_cyc = cyc;
        if (m_valid === 1'b1) mv_high++;
        mv_prev = m_valid;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int frame_c0;

    // Leaves the line at the stop-bit level; callers restore idle if needed.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        tick();
        rx_serial = 1'b0;
        frame_c0  = cyc;
        repeat (CLK_DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            repeat (CLK_DIV) tick();
        end
        rx_serial = stop_bit;
        repeat (CLK_DIV) tick();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_n;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    localparam int NVEC = 7;
    vec_t       vecs[NVEC];
    logic [7:0] t2_exp[3];
    logic [7:0] partial;
    int         f0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
        vecs[4] = '{8'h55, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[6] = '{8'h7E, 1'b1, 1, 8'h7E, 0};
        t2_exp  = '{8'h00, 8'hFF, 8'h3C};
        partial = 8'hC3;

        rst         = 1'b1;
        rx_serial   = 1'b1;
        m_ready     = 1'b0;
        clr_overrun = 1'b0;
        repeat (3) tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        repeat (CLK_DIV) tick();

        // Single 0xA5 frame: latency and one-cycle m_valid pulse.
        m_ready     = 1'b1;
        rxq.delete();
        f0          = ferr_cnt;
        mv_rise_cyc = -1;
        mv_high     = 0;
        send_frame(8'hA5, 1'b1);
        rx_serial = 1'b1;
        repeat (2 * CLK_DIV) tick();
        check_range("t1_latency", mv_rise_cyc - frame_c0, LATENCY - 1, LATENCY + 1);
        check("t1_valid_width", mv_high, 1);
        check("t1_count", rxq.size(), 1);
        if (rxq.size() > 0) check("t1_data", rxq[0], 8'hA5);
        check("t1_ferr", ferr_cnt - f0, 0);
        check("t1_overrun", overrun, 0);

        // Vector table: one frame each, consumer always ready.
        for (int i = 0; i < NVEC; i++) begin
            rxq.delete();
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            rx_serial = 1'b1;
            repeat (2 * CLK_DIV) tick();
            check($sformatf("vec%0d_nbytes", i), rxq.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && rxq.size() > 0)
                check($sformatf("vec%0d_data", i), rxq[0], vecs[i].exp_data);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
        end

        // Three buffered bytes, then drained on consecutive cycles.
        m_ready = 1'b0;
        rxq.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (2 * CLK_DIV) tick();
        check("t2_count3", fifo_count, 3);
        check("t2_head_valid", m_valid, 1);
        check("t2_head_data", m_data, 8'h00);
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t2_pop%0d_valid", k), m_valid, 1);
            check($sformatf("t2_pop%0d_data", k), m_data, t2_exp[k]);
        end
        @(negedge clk);
        check("t2_empty_valid", m_valid, 0);
        check("t2_empty_count", fifo_count, 0);
        tick();

        // Stop bit low, line held low three more bit periods: one error, no byte.
        rxq.delete();
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        repeat (3 * CLK_DIV) tick();
        rx_serial = 1'b1;
        repeat (2 * CLK_DIV) tick();
        check("t3_ferr_once", ferr_cnt - f0, 1);
        check("t3_no_byte", rxq.size(), 0);
        check("t3_count", fifo_count, 0);
        send_frame(8'h81, 1'b1);
        repeat (2 * CLK_DIV) tick();
        check("t3_recover_n", rxq.size(), 1);
        if (rxq.size() > 0) check("t3_recover_data", rxq[0], 8'h81);

        // Nine bytes into a depth-8 FIFO with no consumer.
        m_ready = 1'b0;
        rxq.delete();
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1);
        repeat (2 * CLK_DIV) tick();
        check("t4_full_count", fifo_count, 8);
        check("t4_overrun_set", overrun, 1);
        check("t4_head", m_data, 8'h01);
        repeat (3) tick();
        check("t4_overrun_sticky", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t4_overrun_clr", overrun, 0);
        m_ready = 1'b1;
        repeat (12) tick();
        check("t4_drain_n", rxq.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t4_drain%0d", i), rxq[i], 8'(i + 1));
        check("t4_drain_count", fifo_count, 0);

        // Four-cycle idle glitch.
        rxq.delete();
        f0 = ferr_cnt;
        tick();
        rx_serial = 1'b0;
        repeat (4) tick();
        rx_serial = 1'b1;
        repeat (3 * CLK_DIV) tick();
        check("t5_no_byte", rxq.size(), 0);
        check("t5_no_ferr", ferr_cnt - f0, 0);
        check("t5_valid", m_valid, 0);
        send_frame(8'h5A, 1'b1);
        repeat (2 * CLK_DIV) tick();
        check("t5_after_n", rxq.size(), 1);
        if (rxq.size() > 0) check("t5_after_data", rxq[0], 8'h5A);

        // Reset in the middle of a frame with two bytes buffered.
        m_ready = 1'b0;
        rxq.delete();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2 * CLK_DIV) tick();
        check("t6_pre_count", fifo_count, 2);
        tick();
        rx_serial = 1'b0;
        repeat (CLK_DIV) tick();
        for (int i = 0; i < 4; i++) begin
            rx_serial = partial[i];
            repeat (CLK_DIV) tick();
        end
        rst       = 1'b1;
        rx_serial = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_count", fifo_count, 0);
        check("t6_valid", m_valid, 0);
        check("t6_data", m_data, 8'h00);
        repeat (2 * CLK_DIV) tick();
        m_ready = 1'b1;
        rxq.delete();
        f0 = ferr_cnt;
        send_frame(8'h7E, 1'b1);
        repeat (2 * CLK_DIV) tick();
        check("t6_next_n", rxq.size(), 1);
        if (rxq.size() > 0) check("t6_next_data", rxq[0], 8'h7E);
        check("t6_next_ferr", ferr_cnt - f0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
